// File: rtl/grammer_test_pkg.sv
// Shared definitions for the grammer_test command accumulator:
// opcode values, run/halt FSM states and status-word bit positions.
package grammer_test_pkg;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_LOAD  = 4'h1;
  localparam logic [3:0] OP_ADD   = 4'h2;
  localparam logic [3:0] OP_SUB   = 4'h3;
  localparam logic [3:0] OP_AND   = 4'h4;
  localparam logic [3:0] OP_OR    = 4'h5;
  localparam logic [3:0] OP_XOR   = 4'h6;
  localparam logic [3:0] OP_SHL   = 4'h7;
  localparam logic [3:0] OP_SHR   = 4'h8;
  localparam logic [3:0] OP_CMPEQ = 4'h9;
  localparam logic [3:0] OP_CLRF  = 4'hA;
  localparam logic [3:0] OP_HALT  = 4'hF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  // Status word: {halted, flag, ovf, zero padding, cnt}
  localparam int ST_HALT_BIT = 31;
  localparam int ST_FLAG_BIT = 30;
  localparam int ST_OVF_BIT  = 29;

endpackage

// File: rtl/grammer_test_alu.sv
// Combinational ALU: computes the post-command accumulator, compare flag and
// sticky overflow for one command. Gating by FSM state is done in the top.
module grammer_test_alu
  import grammer_test_pkg::*;
(
  input  logic [31:0] acc,
  input  logic [3:0]  op,
  input  logic [15:0] imm,
  input  logic        flag,
  input  logic        ovf,
  output logic [31:0] acc_n,
  output logic        flag_n,
  output logic        ovf_n
);

  logic [31:0] imm_z;
  logic [31:0] imm_s;
  logic [31:0] sum;
  logic [31:0] diff;

  assign imm_z = {16'h0000, imm};
  assign imm_s = {{16{imm[15]}}, imm};
  assign sum   = acc + imm_s;
  assign diff  = acc - imm_s;

  // Signed overflow: operands that look alike (add) or differ (sub) in sign
  // produce a result whose sign differs from the accumulator's.
  always_comb begin
    acc_n  = acc;
    flag_n = flag;
    ovf_n  = ovf;
    case (op)
      OP_LOAD:  acc_n = imm_z;
      OP_ADD: begin
        acc_n = sum;
        if ((acc[31] == imm_s[31]) && (sum[31] != acc[31])) ovf_n = 1'b1;
      end
      OP_SUB: begin
        acc_n = diff;
        if ((acc[31] != imm_s[31]) && (diff[31] != acc[31])) ovf_n = 1'b1;
      end
      OP_AND:   acc_n = acc & imm_z;
      OP_OR:    acc_n = acc | imm_z;
      OP_XOR:   acc_n = acc ^ imm_z;
      OP_SHL:   acc_n = acc << imm[4:0];
      OP_SHR:   acc_n = acc >> imm[4:0];
      OP_CMPEQ: flag_n = (acc == imm_z);
      OP_CLRF: begin
        flag_n = 1'b0;
        ovf_n  = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/grammer_test.sv
// Command-driven accumulator top: state registers, IDLE/RUN/HALT FSM,
// saturating executed-command counter and the registered display mux.
module grammer_test
  import grammer_test_pkg::*;
#(
  parameter int CNT_W = 16   // must not exceed 29 so the status word fits
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] in,
  output logic [31:0] out,
  input  logic        sig_display,
  input  logic        __obs
);

  state_t             state, state_n;
  logic [31:0]        acc, acc_next, alu_acc;
  logic               flag, flag_next, alu_flag;
  logic               ovf, ovf_next, alu_ovf;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic               exec;
  logic [31:0]        status;
  logic [3:0]         op;
  logic [15:0]        imm;
  logic               unused_in;

  assign op        = in[31:28];
  assign imm       = in[15:0];
  assign unused_in = ^in[27:16];

  grammer_test_alu u_alu (
    .acc    (acc),
    .op     (op),
    .imm    (imm),
    .flag   (flag),
    .ovf    (ovf),
    .acc_n  (alu_acc),
    .flag_n (alu_flag),
    .ovf_n  (alu_ovf)
  );

  // A non-NOP command executes in IDLE and RUN; a HALT seen in IDLE halts directly.
  always_comb begin
    state_n = state;
    exec    = 1'b0;
    case (state)
      IDLE: begin
        if (op != OP_NOP) begin
          exec    = 1'b1;
          state_n = (op == OP_HALT) ? HALT : RUN;
        end
      end
      RUN: begin
        if (op != OP_NOP) exec = 1'b1;
        if (op == OP_HALT) state_n = HALT;
      end
      HALT: ;
      default: state_n = IDLE;
    endcase

    acc_next  = exec ? alu_acc  : acc;
    flag_next = exec ? alu_flag : flag;
    ovf_next  = exec ? alu_ovf  : ovf;
    cnt_next  = (exec && (cnt != {CNT_W{1'b1}})) ? cnt + 1'b1 : cnt;

    status              = 32'(cnt_next);
    status[ST_HALT_BIT] = (state_n == HALT);
    status[ST_FLAG_BIT] = flag_next;
    status[ST_OVF_BIT]  = ovf_next;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      acc   <= '0;
      flag  <= 1'b0;
      ovf   <= 1'b0;
      cnt   <= '0;
      out   <= '0;
    end else begin
      state <= state_n;
      acc   <= acc_next;
      flag  <= flag_next;
      ovf   <= ovf_next;
      cnt   <= cnt_next;
      if (__obs)
        out <= status;
      else if (sig_display)
        out <= acc_next;
    end
  end

endmodule

// File: tb/tb_grammer_test.sv
// Scoreboard bench for grammer_test: directed and random commands feed a
// behavioural model whose expected out values are checked by a monitor.
module tb_grammer_test;
  import grammer_test_pkg::*;

  localparam int CNT_W   = 16;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] in;
  logic [31:0] out;
  logic        sig_display;
  logic        obs;

  always #5 clk = ~clk;

  grammer_test #(.CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .in          (in),
    .out         (out),
    .sig_display (sig_display),
    .__obs       (obs)
  );

  typedef struct {
    logic [31:0] value;
    string       tag;
  } exp_t;

  exp_t exp_q[$];
  int   n_compared   = 0;
  int   n_mismatched = 0;

  // Reference model: plain architectural state, updated from the command rules.
  logic [31:0] m_acc    = '0;
  logic [31:0] m_out    = '0;
  bit          m_flag   = 1'b0;
  bit          m_ovf    = 1'b0;
  bit          m_halted = 1'b0;
  int          m_cnt    = 0;

  function automatic logic [31:0] cmd(input logic [3:0] op, input logic [15:0] imm);
    return {op, 12'($urandom), imm};
  endfunction

  task automatic model_step(input bit rst_n, input logic [31:0] c, input bit disp, input bit ob);
    logic [3:0]  op;
    logic [15:0] imm;
    longint      a_s, i_s, s;
    op  = c[31:28];
    imm = c[15:0];
    if (!rst_n) begin
      m_acc = '0; m_flag = 0; m_ovf = 0; m_halted = 0; m_cnt = 0; m_out = '0;
      return;
    end
    if (!m_halted && op != 4'h0) begin
      a_s = longint'($signed(m_acc));
      i_s = longint'($signed(imm));
      case (op)
        4'h1: m_acc = {16'h0, imm};
        4'h2, 4'h3: begin
          s = (op == 4'h2) ? a_s + i_s : a_s - i_s;
          if (s > 64'sd2147483647 || s < -64'sd2147483648) m_ovf = 1;
          m_acc = s[31:0];
        end
        4'h4: m_acc = m_acc & {16'h0, imm};
        4'h5: m_acc = m_acc | {16'h0, imm};
        4'h6: m_acc = m_acc ^ {16'h0, imm};
        4'h7: m_acc = m_acc << imm[4:0];
        4'h8: m_acc = m_acc >> imm[4:0];
        4'h9: m_flag = (m_acc == {16'h0, imm});
        4'hA: begin m_flag = 0; m_ovf = 0; end
        4'hF: m_halted = 1;
        default: ;
      endcase
      if (m_cnt < CNT_MAX) m_cnt++;
    end
    if (ob)
      m_out = {m_halted, m_flag, m_ovf, 29'(m_cnt)};
    else if (disp)
      m_out = m_acc;
  endtask

  task automatic applyStimulus(input bit rst_n, input logic [31:0] c, input bit disp,
                               input bit ob, input string tag);
    exp_t e;
    @(negedge clk);
    reset       = rst_n;
    in          = c;
    sig_display = disp;
    obs         = ob;
    model_step(rst_n, c, disp, ob);
    e.value = m_out;
    e.tag   = tag;
    exp_q.push_back(e);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] expv);
    n_compared++;
    if (out !== expv) begin
      n_mismatched++;
      $display("[TB] FAIL %s: out=0x%08h expected 0x%08h", tag, out, expv);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput(e.tag, e.value);
      end
    end
  end

  initial begin : stimulus
    logic [3:0]  rop;
    logic [15:0] rimm;
    reset = 1'b0; in = '0; sig_display = 1'b0; obs = 1'b0;

    repeat (2) applyStimulus(0, $urandom, 1'($urandom), 1'($urandom), "reset_hold");
    applyStimulus(1, cmd(OP_NOP, 16'h0), 0, 1, "obs_after_reset");

    applyStimulus(1, cmd(OP_LOAD, 16'h0010), 1, 0, "load_10");
    applyStimulus(1, cmd(OP_ADD,  16'hFFFF), 1, 0, "add_minus1");
    applyStimulus(1, cmd(OP_NOP,  16'h0),    0, 1, "obs_cnt2");

    applyStimulus(1, cmd(OP_LOAD, 16'h7FFF), 1, 0, "ovf_load");
    applyStimulus(1, cmd(OP_SHL,  16'd16),   1, 0, "ovf_shl16");
    applyStimulus(1, cmd(OP_ADD,  16'h7FFF), 1, 0, "ovf_add1");
    applyStimulus(1, cmd(OP_ADD,  16'h7FFF), 1, 0, "ovf_add2");
    applyStimulus(1, cmd(OP_ADD,  16'h0001), 1, 0, "ovf_add3");
    applyStimulus(1, cmd(OP_ADD,  16'h0001), 1, 0, "ovf_wrap");
    applyStimulus(1, cmd(OP_NOP,  16'h0),    0, 1, "obs_ovf_set");
    applyStimulus(1, cmd(OP_CLRF, 16'h0),    0, 1, "clrf");
    applyStimulus(1, cmd(OP_SUB,  16'h0001), 1, 1, "sub_ovf_obs");

    applyStimulus(1, cmd(OP_LOAD,  16'h00F0), 1, 0, "logic_load");
    applyStimulus(1, cmd(OP_XOR,   16'h00FF), 1, 0, "logic_xor");
    applyStimulus(1, cmd(OP_CMPEQ, 16'h000F), 0, 1, "cmpeq_true");
    applyStimulus(1, cmd(OP_SHR,   16'd2),    1, 0, "shr2");
    applyStimulus(1, cmd(OP_OR,    16'hA500), 1, 0, "or");
    applyStimulus(1, cmd(OP_AND,   16'h0F0F), 1, 0, "and");
    applyStimulus(1, cmd(4'hC,     16'h1234), 0, 1, "op_c_counts");

    applyStimulus(1, cmd(OP_LOAD, 16'h1234), 1, 1, "obs_priority");
    for (int i = 0; i < 5; i++)
      applyStimulus(1, cmd(4'($urandom_range(1, 14)), 16'($urandom)), 0, 0, "hold");

    applyStimulus(0, $urandom, 0, 0, "halt_pre_reset");
    applyStimulus(1, cmd(OP_LOAD, 16'd5), 1, 0, "halt_load5");
    applyStimulus(1, cmd(OP_HALT, 16'd0), 0, 0, "halt_cmd");
    applyStimulus(1, cmd(OP_LOAD, 16'd9), 1, 0, "halt_ignores_load");
    applyStimulus(1, cmd(OP_NOP,  16'd0), 0, 1, "halt_obs");
    applyStimulus(0, $urandom, 1, 1, "halt_reset");
    applyStimulus(1, cmd(OP_NOP,  16'd0), 0, 1, "obs_after_halt_reset");
    applyStimulus(1, cmd(OP_LOAD, 16'd7), 0, 0, "halt_disp_load");
    applyStimulus(1, cmd(OP_HALT, 16'd0), 1, 0, "halt_with_display");
    applyStimulus(0, $urandom, 0, 0, "idle_reset");
    applyStimulus(1, cmd(OP_HALT, 16'd3), 0, 1, "halt_from_idle");

    for (int i = 0; i < 600; i++) begin
      rop  = ($urandom_range(0, 99) < 3) ? OP_HALT : 4'($urandom_range(0, 14));
      rimm = ($urandom_range(0, 3) == 0) ? m_acc[15:0] : 16'($urandom);
      applyStimulus($urandom_range(0, 59) != 0, cmd(rop, rimm),
                    1'($urandom), $urandom_range(0, 3) == 0, "random");
    end

    applyStimulus(0, $urandom, 0, 0, "sat_reset");
    for (int i = 0; i < CNT_MAX + 6; i++)
      applyStimulus(1, cmd(OP_ADD, 16'd1), 0, (i % 8192) == 0 || i >= CNT_MAX - 2, "saturate");
    applyStimulus(1, cmd(OP_HALT, 16'd0), 0, 1, "sat_halt");

    repeat (3) @(negedge clk);
    n_compared++;
    if (exp_q.size() != 0) begin
      n_mismatched++;
      $display("[TB] FAIL drain: pending=%0d expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
